// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-2 Booth multiplier with valid/ready handshakes on both sides.
// Operands are extended to WIDTH+1 bits so one datapath serves signed and unsigned modes.
module seq_booth_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out
);

   localparam int CNT_W = $clog2(WIDTH + 2);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                   state_q, state_d;
   logic signed [WIDTH:0]    a_q, a_d;
   logic signed [WIDTH:0]    m_q, m_d;
   logic [WIDTH:0]           q_q, q_d;
   logic                     qm1_q, qm1_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0]       out_q, out_d;

   logic signed [WIDTH:0]    sum;
   logic signed [WIDTH:0]    a_sh;
   logic [WIDTH:0]           q_sh;

   always_comb begin
      sum = a_q;
      unique case ({q_q[0], qm1_q})
         2'b01:   sum = a_q + m_q;
         2'b10:   sum = a_q - m_q;
         default: sum = a_q;
      endcase
      // Arithmetic right shift of the combined {A,Q,q_-1} register.
      a_sh = sum >>> 1;
      q_sh = {sum[0], q_q[WIDTH:1]};
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      m_d         = m_q;
      q_d         = q_q;
      qm1_d       = qm1_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               m_d        = {signed_mode & in1[WIDTH-1], in1};
               q_d        = {signed_mode & in2[WIDTH-1], in2};
               a_d        = '0;
               qm1_d      = 1'b0;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = CALC;
            end
         end
         CALC: begin
            a_d   = a_sh;
            q_d   = q_sh;
            qm1_d = q_q[0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               out_d       = {a_sh[WIDTH-2:0], q_sh};
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         m_q         <= '0;
         q_q         <= '0;
         qm1_q       <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         m_q         <= m_d;
         q_q         <= q_d;
         qm1_q       <= qm1_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;

endmodule
